pnl_bram_arbiter: RTL and testbench

Two-port round-robin arbiter and access sequencer for the 8K x 16 single-port block RAM (`design_1_blk_mem_gen_0_0`, port A). It sits between the RAM and two requesters, typically the PL engine and the GPIO command path. It serialises their read and write transactions and drives the RAM's addr/we/data pins. It also absorbs the RAM's read latency and returns each read word with a one-cycle acknowledge.

---
 rtl/pnl_bram_pkg.sv | 17 +
 rtl/pnl_bram_arbiter_if.sv | 46 ++++
 rtl/pnl_bram_arbiter_rr_arb2.sv | 15 +
 rtl/pnl_bram_arbiter.sv | 141 ++++++++++++++
 tb/tb_pnl_bram_arbiter.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/pnl_bram_pkg.sv
// Shared types and constants for the two-port block RAM arbiter.
package pnl_bram_pkg;

  localparam int ADDR_W_DEF = 13;
  localparam int DATA_W_DEF = 16;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/pnl_bram_arbiter_if.sv
// Requester and RAM-side signal bundle; master = requesters/RAM, slave = arbiter.
interface pnl_bram_arbiter_if
  import pnl_bram_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic              REQ0_req;
  logic              REQ0_we;
  logic [ADDR_W-1:0] REQ0_addr;
  logic [DATA_W-1:0] REQ0_wdata;
  logic              REQ0_ack;
  logic [DATA_W-1:0] REQ0_rdata;

  logic              REQ1_req;
  logic              REQ1_we;
  logic [ADDR_W-1:0] REQ1_addr;
  logic [DATA_W-1:0] REQ1_wdata;
  logic              REQ1_ack;
  logic [DATA_W-1:0] REQ1_rdata;

  logic [ADDR_W-1:0] BRAM_PORTA_addr;
  logic [DATA_W-1:0] BRAM_PORTA_dout;
  logic [DATA_W-1:0] BRAM_PORTA_din;
  logic              BRAM_PORTA_we;

  modport master (
    output REQ0_req, REQ0_we, REQ0_addr, REQ0_wdata,
    input  REQ0_ack, REQ0_rdata,
    output REQ1_req, REQ1_we, REQ1_addr, REQ1_wdata,
    input  REQ1_ack, REQ1_rdata,
    input  BRAM_PORTA_addr, BRAM_PORTA_dout, BRAM_PORTA_we,
    output BRAM_PORTA_din
  );

  modport slave (
    input  REQ0_req, REQ0_we, REQ0_addr, REQ0_wdata,
    output REQ0_ack, REQ0_rdata,
    input  REQ1_req, REQ1_we, REQ1_addr, REQ1_wdata,
    output REQ1_ack, REQ1_rdata,
    output BRAM_PORTA_addr, BRAM_PORTA_dout, BRAM_PORTA_we,
    input  BRAM_PORTA_din
  );

endinterface

// File: rtl/pnl_bram_arbiter_rr_arb2.sv
// Two-way round-robin picker: the pointed-to port wins when it requests.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       ptr,
  input  logic       advance,
  output logic       grant,
  output logic       valid
);

  always_comb begin
    valid = advance && (req != 2'b00);
    grant = req[ptr] ? ptr : ~ptr;
  end

endmodule

// File: rtl/pnl_bram_arbiter.sv
// Serialises two requesters onto one single-port block RAM and hides its read latency.
module pnl_bram_arbiter
  import pnl_bram_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int RD_LAT = 2
) (
  input  logic              Clk,
  input  logic              RESET,
  pnl_bram_arbiter_if.slave bus,
  output logic              busy,
  output logic              owner
);

  if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_bad_rd_lat
    $error("pnl_bram_arbiter: RD_LAT must be within 1..3");
  end

  localparam logic [1:0] CNT_INIT = 2'(RD_LAT - 1);

  state_e            state_reg, state_next;
  logic              ptr_reg;
  logic              owner_reg;
  logic              busy_reg;
  logic              we_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] dout_reg;
  logic [1:0]        cnt_reg;
  logic              ack_reg   [2];
  logic [DATA_W-1:0] rdata_reg [2];

  logic [1:0]        req_vec;
  logic              we_arr    [2];
  logic [ADDR_W-1:0] addr_arr  [2];
  logic [DATA_W-1:0] wdata_arr [2];
  logic              grant, grant_valid;
  logic              load, capture, enter_done;

  assign req_vec      = {bus.REQ1_req, bus.REQ0_req};
  assign we_arr[0]    = bus.REQ0_we;
  assign we_arr[1]    = bus.REQ1_we;
  assign addr_arr[0]  = bus.REQ0_addr;
  assign addr_arr[1]  = bus.REQ1_addr;
  assign wdata_arr[0] = bus.REQ0_wdata;
  assign wdata_arr[1] = bus.REQ1_wdata;

  rr_arb2 u_arb (
    .req     (req_vec),
    .ptr     (ptr_reg),
    .advance (state_reg == IDLE),
    .grant   (grant),
    .valid   (grant_valid)
  );

  always_comb begin
    state_next = state_reg;
    load       = 1'b0;
    capture    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (grant_valid) begin
          state_next = ISSUE;
          load       = 1'b1;
        end
      end
      // we_reg is only high in ISSUE, so it doubles as the latched direction
      ISSUE:   state_next = we_reg ? DONE : WAIT;
      WAIT: begin
        if (cnt_reg == 2'd0) begin
          state_next = DONE;
          capture    = 1'b1;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign enter_done = (state_next == DONE) && (state_reg != DONE);

  always_ff @(posedge Clk or posedge RESET) begin
    if (RESET) begin
      state_reg <= IDLE;
      ptr_reg   <= 1'b0;
      owner_reg <= 1'b0;
      busy_reg  <= 1'b0;
      we_reg    <= 1'b0;
      addr_reg  <= '0;
      dout_reg  <= '0;
      cnt_reg   <= 2'd0;
    end else begin
      state_reg <= state_next;
      busy_reg  <= (state_next != IDLE);
      we_reg    <= 1'b0;
      if (load) begin
        owner_reg <= grant;
        addr_reg  <= addr_arr[grant];
        we_reg    <= we_arr[grant];
        if (we_arr[grant]) begin
          dout_reg <= wdata_arr[grant];
        end
      end
      if (state_reg == ISSUE) begin
        cnt_reg <= CNT_INIT;
      end else if (state_reg == WAIT) begin
        cnt_reg <= cnt_reg - 2'd1;
      end
      // Favour the port that was not just served
      if (state_reg == DONE) begin
        ptr_reg <= ~owner_reg;
      end
    end
  end

  genvar gi;
  for (gi = 0; gi < 2; gi++) begin : g_port
    always_ff @(posedge Clk or posedge RESET) begin
      if (RESET) begin
        ack_reg[gi]   <= 1'b0;
        rdata_reg[gi] <= '0;
      end else begin
        ack_reg[gi] <= enter_done && (owner_reg == 1'(gi));
        if (capture && (owner_reg == 1'(gi))) begin
          rdata_reg[gi] <= bus.BRAM_PORTA_din;
        end
      end
    end
  end

  assign bus.REQ0_ack        = ack_reg[0];
  assign bus.REQ1_ack        = ack_reg[1];
  assign bus.REQ0_rdata      = rdata_reg[0];
  assign bus.REQ1_rdata      = rdata_reg[1];
  assign bus.BRAM_PORTA_addr = addr_reg;
  assign bus.BRAM_PORTA_dout = dout_reg;
  assign bus.BRAM_PORTA_we   = we_reg;
  assign busy                = busy_reg;
  assign owner               = owner_reg;

endmodule

// File: tb/tb_pnl_bram_arbiter.sv
// Directed bench: three arbiters (RD_LAT 2, 1, 3) each with a behavioural RAM model.
module tb_pnl_bram_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Per-instance requester drive and observed outputs
  logic        req_r   [3][2];
  logic        we_r    [3][2];
  logic [12:0] addr_r  [3][2];
  logic [15:0] wd_r    [3][2];
  logic        ack_w   [3][2];
  logic [15:0] rdata_w [3][2];
  logic        busy_w  [3];
  logic        owner_w [3];
  logic        bwe_w   [3];
  logic [12:0] baddr_w [3];
  logic [15:0] bdout_w [3];

  genvar gi;
  for (gi = 0; gi < 3; gi++) begin : g_inst
    localparam int L = (gi == 0) ? 2 : ((gi == 1) ? 1 : 3);
    pnl_bram_arbiter_if #(.ADDR_W(13), .DATA_W(16)) bus ();
    logic [15:0] mem  [0:8191];
    logic [15:0] pipe [0:L-1];

    assign bus.REQ0_req   = req_r[gi][0];
    assign bus.REQ0_we    = we_r[gi][0];
    assign bus.REQ0_addr  = addr_r[gi][0];
    assign bus.REQ0_wdata = wd_r[gi][0];
    assign bus.REQ1_req   = req_r[gi][1];
    assign bus.REQ1_we    = we_r[gi][1];
    assign bus.REQ1_addr  = addr_r[gi][1];
    assign bus.REQ1_wdata = wd_r[gi][1];
    assign ack_w[gi][0]   = bus.REQ0_ack;
    assign ack_w[gi][1]   = bus.REQ1_ack;
    assign rdata_w[gi][0] = bus.REQ0_rdata;
    assign rdata_w[gi][1] = bus.REQ1_rdata;
    assign bwe_w[gi]      = bus.BRAM_PORTA_we;
    assign baddr_w[gi]    = bus.BRAM_PORTA_addr;
    assign bdout_w[gi]    = bus.BRAM_PORTA_dout;

    always_ff @(posedge clk) begin
      if (bus.BRAM_PORTA_we) mem[bus.BRAM_PORTA_addr] <= bus.BRAM_PORTA_dout;
      pipe[0] <= mem[bus.BRAM_PORTA_addr];
      for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
    end
    assign bus.BRAM_PORTA_din = pipe[L-1];

    pnl_bram_arbiter #(.ADDR_W(13), .DATA_W(16), .RD_LAT(L)) dut (
      .Clk   (clk),
      .RESET (rst),
      .bus   (bus),
      .busy  (busy_w[gi]),
      .owner (owner_w[gi])
    );
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Per-port scripts: reads carry the expected read data in s_wd
  logic        s_we   [2][16];
  logic [12:0] s_addr [2][16];
  logic [15:0] s_wd   [2][16];
  int          s_n    [2];
  int          lat_r  [2][16];
  int          ord    [$];
  int          last_we;

  task automatic clear_ops();
    s_n[0] = 0;
    s_n[1] = 0;
  endtask

  task automatic add_op(input int p, input logic we, input logic [12:0] a, input logic [15:0] d);
    s_we[p][s_n[p]]   = we;
    s_addr[p][s_n[p]] = a;
    s_wd[p][s_n[p]]   = d;
    s_n[p]++;
  endtask

  task automatic load_op(input int k, input int p, input int i);
    req_r[k][p]  = 1'b1;
    we_r[k][p]   = s_we[p][i];
    addr_r[k][p] = s_addr[p][i];
    wd_r[k][p]   = s_wd[p][i];
  endtask

  // Both ports run their scripts concurrently; req stays high while ops remain
  task automatic run_dual(input int k, input string name);
    int idx [2];
    int start [2];
    bit upd [2];
    int cyc;
    idx = '{0, 0};
    start = '{0, 0};
    ord.delete();
    last_we = 0;
    cyc = 0;
    @(posedge clk); #1;
    for (int p = 0; p < 2; p++) if (s_n[p] > 0) load_op(k, p, 0);
    while ((idx[0] < s_n[0] || idx[1] < s_n[1]) && cyc < 300) begin
      @(negedge clk);
      if (bwe_w[k]) last_we++;
      for (int p = 0; p < 2; p++) begin
        upd[p] = 1'b0;
        if (ack_w[k][p] && idx[p] < s_n[p]) begin
          ord.push_back(p);
          lat_r[p][idx[p]] = cyc - start[p];
          $display("txn %s inst=%0d port=%0d %s addr=%04h data=%04h latency=%0d", name, k, p,
                   s_we[p][idx[p]] ? "WR" : "RD", s_addr[p][idx[p]],
                   s_we[p][idx[p]] ? s_wd[p][idx[p]] : rdata_w[k][p], cyc - start[p]);
          if (!s_we[p][idx[p]])
            chk($sformatf("%s_rdata_p%0d_op%0d", name, p, idx[p]), 32'(rdata_w[k][p]), 32'(s_wd[p][idx[p]]));
          idx[p]++;
          upd[p] = 1'b1;
        end
      end
      @(posedge clk); #1;
      cyc++;
      for (int p = 0; p < 2; p++) begin
        if (upd[p]) begin
          if (idx[p] < s_n[p]) begin
            load_op(k, p, idx[p]);
            start[p] = cyc;
          end else begin
            req_r[k][p] = 1'b0;
          end
        end
      end
    end
    chk($sformatf("%s_completed_in_budget", name), 32'(cyc < 300), 32'h1);
  endtask

  int exp_ord [9];
  int seen_ack;

  initial begin
    for (int k = 0; k < 3; k++) begin
      for (int p = 0; p < 2; p++) begin
        req_r[k][p] = 1'b0; we_r[k][p] = 1'b0; addr_r[k][p] = '0; wd_r[k][p] = '0;
      end
    end
    clear_ops();

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy_w[0]), 0);
    chk("rst_owner", 32'(owner_w[0]), 0);
    chk("rst_we", 32'(bwe_w[0]), 0);
    chk("rst_addr", 32'(baddr_w[0]), 0);
    chk("rst_rdata0", 32'(rdata_w[0][0]), 0);
    chk("rst_ack1", 32'(ack_w[0][1]), 0);
    rst = 1'b0;

    // Tie right after reset: port 0 first, then cross read-backs
    clear_ops();
    add_op(0, 1'b1, 13'h0000, 16'h1111);
    add_op(0, 1'b0, 13'h1FFF, 16'h2222);
    add_op(1, 1'b1, 13'h1FFF, 16'h2222);
    add_op(1, 1'b0, 13'h0000, 16'h1111);
    run_dual(0, "tie");
    chk("tie_count", 32'(ord.size()), 4);
    exp_ord = '{0, 1, 0, 1, 0, 0, 0, 0, 0};
    for (int i = 0; i < 4 && i < ord.size(); i++) chk($sformatf("tie_order%0d", i), 32'(ord[i]), 32'(exp_ord[i]));
    chk("tie_lat_p0", 32'(lat_r[0][0]), 2);
    chk("tie_lat_p1", 32'(lat_r[1][0]), 5);

    // Write/read round trip on port 0
    clear_ops();
    add_op(0, 1'b1, 13'h0005, 16'hBEEF);
    add_op(0, 1'b0, 13'h0005, 16'hBEEF);
    run_dual(0, "rt");
    chk("rt_wr_lat", 32'(lat_r[0][0]), 2);
    chk("rt_rd_lat", 32'(lat_r[0][1]), 4);
    chk("rt_we_cycles", 32'(last_we), 1);

    clear_ops();
    add_op(0, 1'b1, 13'h0006, 16'h1234);
    run_dual(0, "wr6");
    clear_ops();
    add_op(1, 1'b0, 13'h0006, 16'h1234);
    run_dual(0, "rd6");
    chk("rdata0_held", 32'(rdata_w[0][0]), 32'hBEEF);
    chk("owner_last", 32'(owner_w[0]), 1);

    // No starvation: port 0 holds req for 6 writes, port 1 posts 3 reads
    clear_ops();
    for (int i = 0; i < 6; i++) add_op(0, 1'b1, 13'(16 + i), 16'(32'hA000 + i));
    add_op(1, 1'b0, 13'h0005, 16'hBEEF);
    add_op(1, 1'b0, 13'h0000, 16'h1111);
    add_op(1, 1'b0, 13'h1FFF, 16'h2222);
    run_dual(0, "starve");
    chk("starve_count", 32'(ord.size()), 9);
    exp_ord = '{0, 1, 0, 1, 0, 1, 0, 0, 0};
    for (int i = 0; i < 9 && i < ord.size(); i++) chk($sformatf("starve_order%0d", i), 32'(ord[i]), 32'(exp_ord[i]));
    chk("starve_we_cycles", 32'(last_we), 6);

    // Reset abort during WAIT of a read
    @(posedge clk); #1;
    req_r[0][0] = 1'b1; we_r[0][0] = 1'b0; addr_r[0][0] = 13'h0010;
    repeat (3) @(negedge clk);
    chk("abort_busy_before", 32'(busy_w[0]), 1);
    rst = 1'b1;
    req_r[0][0] = 1'b0;
    @(posedge clk); #1;
    chk("abort_busy", 32'(busy_w[0]), 0);
    chk("abort_owner", 32'(owner_w[0]), 0);
    chk("abort_we", 32'(bwe_w[0]), 0);
    chk("abort_addr", 32'(baddr_w[0]), 0);
    chk("abort_dout", 32'(bdout_w[0]), 0);
    chk("abort_rdata0", 32'(rdata_w[0][0]), 0);
    chk("abort_rdata1", 32'(rdata_w[0][1]), 0);
    @(negedge clk);
    rst = 1'b0;
    seen_ack = 0;
    repeat (6) begin
      @(negedge clk);
      if (ack_w[0][0] || ack_w[0][1]) seen_ack++;
    end
    chk("abort_no_ack", 32'(seen_ack), 0);

    // Pointer must be back to port 0 after reset
    clear_ops();
    add_op(0, 1'b0, 13'h0000, 16'h1111);
    add_op(1, 1'b0, 13'h1FFF, 16'h2222);
    run_dual(0, "post_rst");
    chk("post_rst_count", 32'(ord.size()), 2);
    if (ord.size() == 2) begin
      chk("post_rst_first", 32'(ord[0]), 0);
      chk("post_rst_second", 32'(ord[1]), 1);
    end
    chk("post_rst_lat_p0", 32'(lat_r[0][0]), 4);
    chk("post_rst_lat_p1", 32'(lat_r[1][0]), 9);

    // Read latency parameter: RD_LAT=1 and RD_LAT=3 instances
    clear_ops();
    add_op(0, 1'b1, 13'h0100, 16'h00AA);
    add_op(0, 1'b0, 13'h0100, 16'h00AA);
    run_dual(1, "lat1");
    chk("lat1_wr", 32'(lat_r[0][0]), 2);
    chk("lat1_rd", 32'(lat_r[0][1]), 3);
    run_dual(2, "lat3");
    chk("lat3_wr", 32'(lat_r[0][0]), 2);
    chk("lat3_rd", 32'(lat_r[0][1]), 5);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
